// File: rtl/bcvs_rx_parser.sv
// rtl/bcvs_rx_parser.sv - BCVS bus-E receive parser: frame/packet tracking, sample RAM writes, error pulses
// Checksum accumulators and PE/FE comparisons exist only when BCVS_RX_CRC_EN is defined.
module bcvs_rx_parser #(
   parameter int SEV_WORDS = 8,
   parameter int ERR_W     = 16
) (
   input  logic                     iclk,
   input  logic                     ireset,
   input  logic [17:0]              iuser_data,
   input  logic                     ivalid,
   output logic [2:0]               oformat,
   output logic [1:0]               oframe_cnt,
   output logic [7:0]               onum_pack,
   output logic [3:0]               ochannels,
   output logic [7:0]               osize_pack,
   output logic [16*SEV_WORDS-1:0]  osev,
   output logic [15:0]              oWr_addr,
   output logic [31:0]              oWr_data,
   output logic                     oWr_en,
   output logic                     opack_done,
   output logic                     oframe_done,
   output logic                     opack_crc_err,
   output logic                     oframe_crc_err,
   output logic                     oproto_err,
   output logic [ERR_W-1:0]         oerr_cnt
);
   localparam int SW = (SEV_WORDS > 1) ? $clog2(SEV_WORDS) : 1;
   localparam logic [17:0] SYNC = 18'h3FE00;

   typedef enum logic [3:0] {
      S_IDLE, S_FH2, S_PH1, S_PH2, S_SEV, S_DATA, S_PE1, S_PE2, S_FE1, S_FE2
   } state_t;
   state_t state;

   logic [7:0]               pidx, nsamp_hi, np_eff;
   logic [SW-1:0]            sev_cnt;
   logic [15:0]              samp_cnt, first_word, nsamp;
   logic                     half;
   logic [16*SEV_WORDS-1:0]  sev_sh;
   logic                     is_sync, is_svc, is_data, is_fh1, ok, acc, frame_start;
   logic [2:0]               tag;

   // ok: the word is what the current state expects, structurally
   always_comb begin
      is_sync = (iuser_data == SYNC);
      is_svc  = (iuser_data[17:16] == 2'b11) && !is_sync;
      is_data = (iuser_data[17:16] == 2'b01);
      tag     = iuser_data[15:13];
      is_fh1  = is_svc && (tag == 3'd0);
      nsamp   = {osize_pack, 8'h00};
      np_eff  = (onum_pack == 8'd0) ? 8'd1 : onum_pack;
      ok      = 1'b0;
      case (state)
         S_IDLE:        ok = is_sync || is_fh1;
         S_FH2:         ok = is_svc && tag == 3'd1 && !iuser_data[12] && iuser_data[7:0] != 8'd0;
         S_PH1:         ok = is_svc && tag == 3'd2 && iuser_data[12:8] == pidx[4:0];
         S_PH2:         ok = is_svc && tag == 3'd3 && iuser_data[12:8] == 5'd0
                             && {nsamp_hi, iuser_data[7:0]} == nsamp;
         S_SEV, S_DATA: ok = is_data;
         S_PE1:         ok = is_svc && tag == 3'd6 && iuser_data[12:8] == 5'd0;
         S_PE2:         ok = is_svc && tag == 3'd7 && iuser_data[12:8] == 5'd0;
         S_FE1:         ok = is_svc && tag == 3'd4 && iuser_data[12:8] == 5'd0;
         S_FE2:         ok = is_svc && tag == 3'd5 && iuser_data[12:8] == 5'd0;
         default:       ok = 1'b0;
      endcase
      acc         = ivalid && ok;
      frame_start = ivalid && is_fh1 && (state == S_IDLE || !ok);
   end

   always_ff @(posedge iclk) begin
      if (ireset) begin
         state <= S_IDLE;
         oformat <= '0; oframe_cnt <= '0; onum_pack <= '0; ochannels <= '0; osize_pack <= '0;
         osev <= '0; sev_sh <= '0; oWr_addr <= '0; oWr_data <= '0; oWr_en <= 1'b0;
         opack_done <= 1'b0; oframe_done <= 1'b0; oproto_err <= 1'b0;
         pidx <= '0; nsamp_hi <= '0; sev_cnt <= '0; samp_cnt <= '0; first_word <= '0; half <= 1'b0;
      end else begin
         oWr_en      <= 1'b0;
         opack_done  <= 1'b0;
         oframe_done <= 1'b0;
         oproto_err  <= 1'b0;
         if (oWr_en)
            oWr_addr <= oWr_addr + 16'd1;
         // An FH1 that breaks the current frame still opens a new one
         if (frame_start) begin
            oformat    <= iuser_data[12:10];
            oframe_cnt <= iuser_data[9:8];
            onum_pack  <= iuser_data[7:0];
            pidx       <= 8'd0;
            state      <= S_FH2;
         end else if (ivalid && !ok) begin
            state <= S_IDLE;
         end
         if (ivalid && !ok)
            oproto_err <= 1'b1;
         if (acc) begin
            case (state)
               S_IDLE: ;
               S_FH2: begin
                  ochannels  <= iuser_data[11:8];
                  osize_pack <= iuser_data[7:0];
                  state      <= S_PH1;
               end
               S_PH1: begin
                  nsamp_hi <= iuser_data[7:0];
                  state    <= S_PH2;
               end
               S_PH2: begin
                  oWr_addr <= '0;
                  samp_cnt <= '0;
                  sev_cnt  <= '0;
                  half     <= 1'b0;
                  state    <= S_SEV;
               end
               S_SEV: begin
                  sev_sh[sev_cnt*16 +: 16] <= iuser_data[15:0];
                  sev_cnt <= sev_cnt + 1'b1;
                  if (sev_cnt == SW'(SEV_WORDS - 1))
                     state <= S_DATA;
               end
               S_DATA: begin
                  if (!half) begin
                     first_word <= iuser_data[15:0];
                     half       <= 1'b1;
                  end else begin
                     half     <= 1'b0;
                     oWr_en   <= 1'b1;
                     oWr_data <= {first_word, iuser_data[15:0]};
                     samp_cnt <= samp_cnt + 16'd1;
                     if (samp_cnt == nsamp - 16'd1)
                        state <= S_PE1;
                  end
               end
               S_PE1: state <= S_PE2;
               S_PE2: begin
                  osev       <= sev_sh;
                  opack_done <= 1'b1;
                  pidx       <= pidx + 8'd1;
                  state      <= ({1'b0, pidx} + 9'd1 < {1'b0, np_eff}) ? S_PH1 : S_FE1;
               end
               S_FE1: state <= S_FE2;
               S_FE2: begin
                  oframe_done <= 1'b1;
                  state       <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef BCVS_RX_CRC_EN
   logic [17:0] pcrc, fcrc;
   logic        pe_bad, fe_bad;

   always_ff @(posedge iclk) begin
      if (ireset) begin
         pcrc <= '0; fcrc <= '0; pe_bad <= 1'b0; fe_bad <= 1'b0;
         opack_crc_err <= 1'b0; oframe_crc_err <= 1'b0;
      end else begin
         opack_crc_err  <= 1'b0;
         oframe_crc_err <= 1'b0;
         if (frame_start) begin
            fcrc <= iuser_data;
         end else if (acc) begin
            case (state)
               S_FH2, S_PH2, S_SEV, S_DATA: begin
                  pcrc <= pcrc + iuser_data;
                  fcrc <= fcrc + iuser_data;
               end
               S_PH1: begin
                  pcrc <= iuser_data;
                  fcrc <= fcrc + iuser_data;
               end
               S_PE1: begin
                  fcrc   <= fcrc + iuser_data;
                  pe_bad <= iuser_data[7:0] != ~pcrc[15:8];
               end
               S_PE2: begin
                  fcrc          <= fcrc + iuser_data;
                  opack_crc_err <= pe_bad || (iuser_data[7:0] != ~pcrc[7:0]);
               end
               S_FE1: fe_bad <= iuser_data[7:0] != ~fcrc[15:8];
               S_FE2: oframe_crc_err <= fe_bad || (iuser_data[7:0] != ~fcrc[7:0]);
               default: ;
            endcase
         end
      end
   end
`else
   assign opack_crc_err  = 1'b0;
   assign oframe_crc_err = 1'b0;
`endif

   logic [1:0]       err_inc;
   logic [ERR_W+1:0] err_sum;

   always_comb begin
      err_inc = 2'(oproto_err) + 2'(opack_crc_err) + 2'(oframe_crc_err);
      err_sum = {2'b00, oerr_cnt} + (ERR_W+2)'(err_inc);
   end

   always_ff @(posedge iclk) begin
      if (ireset)
         oerr_cnt <= '0;
      else if (|err_sum[ERR_W+1:ERR_W])
         oerr_cnt <= '1;
      else
         oerr_cnt <= err_sum[ERR_W-1:0];
   end
endmodule

// File: tb/tb_bcvs_rx_parser.sv
// tb/tb_bcvs_rx_parser.sv - scoreboard bench for bcvs_rx_parser
// A frame generator emits words and, from the frame description, the expected output events.
module tb_bcvs_rx_parser;
   localparam int SEVW = 8;
   localparam int EW   = 2;
`ifdef BCVS_RX_CRC_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif
   localparam logic [17:0] SYNC = 18'h3FE00;
   localparam int K_PROTO = 0, K_WR = 1, K_PCRC = 2, K_PDONE = 3, K_FCRC = 4, K_FDONE = 5;
   localparam int F_NONE = 0, F_PE2 = 1, F_SYNC = 2, F_NSAMP = 3, F_CUT = 4, F_IDX = 5;

   typedef struct {
      int                 kind;
      logic [15:0]        addr;
      logic [31:0]        data;
      logic [16*SEVW-1:0] sev;
   } ev_t;

   logic                iclk = 1'b0;
   logic                ireset = 1'b1;
   logic                ivalid = 1'b0;
   logic [17:0]         iuser_data = '0;
   logic [2:0]          oformat;
   logic [1:0]          oframe_cnt;
   logic [7:0]          onum_pack;
   logic [3:0]          ochannels;
   logic [7:0]          osize_pack;
   logic [16*SEVW-1:0]  osev;
   logic [15:0]         oWr_addr;
   logic [31:0]         oWr_data;
   logic                oWr_en, opack_done, oframe_done, opack_crc_err, oframe_crc_err, oproto_err;
   logic [EW-1:0]       oerr_cnt;

   ev_t         eq[$];
   logic [17:0] wq[$];
   int n_cmp = 0, n_bad = 0, errs = 0, gap_pct = 0;

   bcvs_rx_parser #(.SEV_WORDS(SEVW), .ERR_W(EW)) dut (
      .iclk(iclk), .ireset(ireset), .iuser_data(iuser_data), .ivalid(ivalid),
      .oformat(oformat), .oframe_cnt(oframe_cnt), .onum_pack(onum_pack),
      .ochannels(ochannels), .osize_pack(osize_pack), .osev(osev),
      .oWr_addr(oWr_addr), .oWr_data(oWr_data), .oWr_en(oWr_en),
      .opack_done(opack_done), .oframe_done(oframe_done),
      .opack_crc_err(opack_crc_err), .oframe_crc_err(oframe_crc_err),
      .oproto_err(oproto_err), .oerr_cnt(oerr_cnt)
   );

   always #5 iclk = ~iclk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_ev(input int kind, input logic [15:0] addr, input logic [31:0] data,
                          input logic [16*SEVW-1:0] sev);
      ev_t e;
      e.kind = kind; e.addr = addr; e.data = data; e.sev = sev;
      eq.push_back(e);
      if (kind == K_PROTO || kind == K_PCRC || kind == K_FCRC)
         errs++;
   endtask

   task automatic take(input int kind, input logic [15:0] addr, input logic [31:0] data,
                       input logic [16*SEVW-1:0] sev);
      ev_t e;
      if (eq.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL unexpected_event: got kind %0d expected none", kind);
         return;
      end
      e = eq.pop_front();
      chk("event_kind", 128'(kind), 128'(e.kind));
      if (kind == e.kind) begin
         if (kind == K_WR) begin
            chk("wr_addr", 128'(addr), 128'(e.addr));
            chk("wr_data", 128'(data), 128'(e.data));
         end else if (kind == K_PDONE) begin
            chk("osev", 128'(sev), 128'(e.sev));
         end else if (kind == K_FDONE) begin
            chk("frame_header", 128'(data), 128'(e.data));
         end
      end
   endtask

   always @(negedge iclk) begin
      if (oproto_err)     take(K_PROTO, '0, '0, '0);
      if (oWr_en)         take(K_WR, oWr_addr, oWr_data, '0);
      if (opack_crc_err)  take(K_PCRC, '0, '0, '0);
      if (opack_done)     take(K_PDONE, '0, '0, osev);
      if (oframe_crc_err) take(K_FCRC, '0, '0, '0);
      if (oframe_done)
         take(K_FDONE, '0, {7'd0, oformat, oframe_cnt, onum_pack, ochannels, osize_pack}, '0);
   end

   function automatic logic [17:0] svc(input logic [2:0] tag, input logic [12:0] body);
      return {2'b11, tag, body};
   endfunction

   // Builds one frame; checksums are plain 18-bit sums of the words the rules name
   task automatic gen_frame(input logic [2:0] fmt, input logic [1:0] fcnt, input logic [7:0] np,
                            input logic [3:0] ch, input logic [7:0] sp, input int fault,
                            input int fpack, input int fpos, input bit prefix);
      logic [17:0]        fcrc, pcrc, w;
      logic [15:0]        nsamp, d1, d2;
      logic [16*SEVW-1:0] sev;
      logic [4:0]         pi;
      int                 npe;
      sev   = '0;
      nsamp = {sp, 8'h00};
      npe   = (np == 8'd0) ? 1 : int'(np);
      if (prefix) begin wq.push_back(SYNC); wq.push_back(SYNC); end
      w = svc(3'd0, {fmt, fcnt, np}); wq.push_back(w); fcrc = w;
      w = svc(3'd1, {1'b0, ch, sp});  wq.push_back(w); fcrc += w;
      for (int p = 0; p < npe; p++) begin
         pi = p[4:0];
         if (fault == F_IDX && p == fpack) begin
            wq.push_back(svc(3'd2, {pi + 5'd1, nsamp[15:8]}));
            push_ev(K_PROTO, '0, '0, '0);
            return;
         end
         if (fault == F_NSAMP && p == fpack) begin
            wq.push_back(svc(3'd2, {pi, 8'h02}));
            wq.push_back(svc(3'd3, {5'd0, 8'h00}));
            push_ev(K_PROTO, '0, '0, '0);
            return;
         end
         w = svc(3'd2, {pi, nsamp[15:8]}); wq.push_back(w); pcrc = w;  fcrc += w;
         w = svc(3'd3, {5'd0, nsamp[7:0]}); wq.push_back(w); pcrc += w; fcrc += w;
         for (int s = 0; s < SEVW; s++) begin
            d1 = 16'($urandom); w = {2'b01, d1};
            wq.push_back(w); pcrc += w; fcrc += w;
            sev[16*s +: 16] = d1;
         end
         for (int s = 0; s < int'(nsamp); s++) begin
            d1 = 16'($urandom); d2 = 16'($urandom);
            w = {2'b01, d1}; wq.push_back(w); pcrc += w; fcrc += w;
            w = {2'b01, d2}; wq.push_back(w); pcrc += w; fcrc += w;
            push_ev(K_WR, s[15:0], {d1, d2}, '0);
            if (fault == F_SYNC && p == fpack && s == fpos) begin
               wq.push_back(SYNC);
               push_ev(K_PROTO, '0, '0, '0);
               return;
            end
            if (fault == F_CUT && p == fpack && s == fpos)
               return;
         end
         w = svc(3'd6, {5'd0, ~pcrc[15:8]}); wq.push_back(w); fcrc += w;
         w = svc(3'd7, {5'd0, ~pcrc[7:0]});  fcrc += w;
         if (fault == F_PE2 && p == fpack) begin
            w[7:0] = ~w[7:0];
            if (CRC_EN) push_ev(K_PCRC, '0, '0, '0);
         end
         wq.push_back(w);
         push_ev(K_PDONE, '0, '0, sev);
      end
      wq.push_back(svc(3'd4, {5'd0, ~fcrc[15:8]}));
      wq.push_back(svc(3'd5, {5'd0, ~fcrc[7:0]}));
      if (fault == F_PE2 && CRC_EN) push_ev(K_FCRC, '0, '0, '0);
      push_ev(K_FDONE, '0, {7'd0, fmt, fcnt, np, ch, sp}, '0);
   endtask

   task automatic cyc();
      @(posedge iclk);
      #1;
   endtask

   task automatic drive_all();
      while (wq.size() > 0) begin
         while (int'($urandom_range(99)) < gap_pct) begin
            ivalid = 1'b0;
            iuser_data = 18'($urandom);
            cyc();
         end
         ivalid = 1'b1;
         iuser_data = wq.pop_front();
         cyc();
      end
      ivalid = 1'b0;
   endtask

   task automatic drain(input string name);
      int t;
      int exp_cnt;
      t = 0;
      while (eq.size() > 0 && t < 300) begin cyc(); t++; end
      n_cmp++;
      if (eq.size() != 0) begin
         n_bad++;
         $display("FAIL %s_drain: got %0d pending events expected 0", name, eq.size());
         eq.delete();
      end
      repeat (4) cyc();
      exp_cnt = (errs > 3) ? 3 : errs;
      chk({name, "_err_cnt"}, 128'(oerr_cnt), 128'(exp_cnt));
   endtask

   task automatic do_reset();
      ireset = 1'b1;
      ivalid = 1'b0;
      repeat (3) cyc();
      chk("rst_format", 128'(oformat), 128'(0));
      chk("rst_frame_cnt", 128'(oframe_cnt), 128'(0));
      chk("rst_num_pack", 128'(onum_pack), 128'(0));
      chk("rst_channels", 128'(ochannels), 128'(0));
      chk("rst_size_pack", 128'(osize_pack), 128'(0));
      chk("rst_sev", 128'(osev), 128'(0));
      chk("rst_wr_addr", 128'(oWr_addr), 128'(0));
      chk("rst_wr_data", 128'(oWr_data), 128'(0));
      chk("rst_err_cnt", 128'(oerr_cnt), 128'(0));
      chk("rst_pulses", 128'({oWr_en, opack_done, oframe_done, opack_crc_err,
                               oframe_crc_err, oproto_err}), 128'(0));
      ireset = 1'b0;
      errs = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      gen_frame(3'd2, 2'd1, 8'd2, 4'd3, 8'd1, F_NONE, 0, 0, 1'b1);
      drive_all(); drain("clean");
      gen_frame(3'd2, 2'd1, 8'd2, 4'd3, 8'd1, F_PE2, 1, 0, 1'b1);
      drive_all(); drain("pe2_crc");
      gen_frame(3'd2, 2'd2, 8'd2, 4'd5, 8'd1, F_SYNC, 0, 10, 1'b1);
      gen_frame(3'd5, 2'd3, 8'd2, 4'd6, 8'd1, F_NONE, 0, 0, 1'b1);
      drive_all(); drain("sync_abort");
      gen_frame(3'd1, 2'd0, 8'd2, 4'd1, 8'd1, F_NSAMP, 0, 0, 1'b1);
      gen_frame(3'd3, 2'd1, 8'd1, 4'd2, 8'd1, F_NONE, 0, 0, 1'b1);
      drive_all(); drain("bad_nsamp");
      gap_pct = 30;
      gen_frame(3'd2, 2'd1, 8'd2, 4'd3, 8'd1, F_NONE, 0, 0, 1'b1);
      drive_all(); drain("gaps");
      gap_pct = 0;
      gen_frame(3'd4, 2'd2, 8'd2, 4'd7, 8'd1, F_CUT, 0, 100, 1'b1);
      drive_all(); do_reset(); drain("reset_mid");
      gen_frame(3'd6, 2'd0, 8'd1, 4'd8, 8'd1, F_NONE, 0, 0, 1'b1);
      drive_all(); drain("after_reset");
      // Structure violations back to back, ending in an FH1 that restarts a frame
      gap_pct = 10;
      wq.push_back({2'b01, 16'h1234});
      push_ev(K_PROTO, '0, '0, '0);
      wq.push_back(svc(3'd0, {3'd1, 2'd0, 8'd1}));
      wq.push_back(svc(3'd1, {1'b0, 4'd1, 8'd0}));
      push_ev(K_PROTO, '0, '0, '0);
      gen_frame(3'd7, 2'd1, 8'd3, 4'd9, 8'd1, F_IDX, 1, 0, 1'b1);
      gen_frame(3'd0, 2'd2, 8'd2, 4'd4, 8'd1, F_CUT, 0, 5, 1'b1);
      push_ev(K_PROTO, '0, '0, '0);
      gen_frame(3'd5, 2'd3, 8'd0, 4'd10, 8'd2, F_NONE, 0, 0, 1'b0);
      drive_all(); drain("struct_err");
      gap_pct = 0;
      gen_frame(3'd1, 2'd2, 8'd34, 4'd15, 8'd1, F_NONE, 0, 0, 1'b1);
      drive_all(); drain("idx_wrap");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
